sbox_layer_ctrl: RTL and testbench
==================================

SBOX_LAYER_CTRL -- requirements
Module: sbox_layer_ctrl

Interface
REQ-001 The block SHALL have parameter SBOX_LAT, default 3, giving the cycles from a nibble on sb_in* to its result on sb_out*; legal range 1..8.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all flops sample on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request to run one S-box layer.
REQ-005 The block SHALL have ports state1_in/state2_in/state3_in, input, 64 each, the three Boolean shares of the cipher state.
REQ-006 The block SHALL have port rnd_in, input, 8, fresh randomness, one word per issued nibble.
REQ-007 The block SHALL have port shuffle_seed, input, 4, the first nibble index; it is ignored unless NIBBLE_SHUFFLE_EN is defined.
REQ-008 The block SHALL have ports sb_in1/sb_in2/sb_in3, output, 4 each, the nibble shares sent to the S-box core.
REQ-009 The block SHALL have port sb_r, output, 8, the randomness sent to the S-box core.
REQ-010 The block SHALL have ports sb_out1/sb_out2/sb_out3, input, 4 each, the S-box core result shares.
REQ-011 The block SHALL have ports state1_out/state2_out/state3_out, output, 64 each, the substituted state shares.
REQ-012 The block SHALL have port busy, output, 1, high while a layer is in progress.
REQ-013 The block SHALL have port done, output, 1, a one-cycle completion pulse.

Function
REQ-014 The block SHALL implement FSM IDLE -> FEED (16 cycles) -> DRAIN (SBOX_LAT cycles) -> DONE (1 cycle) -> IDLE.
REQ-015 When start=1 in IDLE or DONE (cycle 0), the block SHALL capture all three input shares, and the seed when enabled, and enter FEED.
REQ-016 A start in FEED or DRAIN SHALL be ignored; input shares SHALL NOT be resampled.
REQ-017 In FEED cycle k (k=0..15, cycles 1..16), the block SHALL drive nibble index i_k = k onto sb_in1..3 (bits 4i+3:4i of each captured share) and rnd_in onto sb_r.
REQ-018 Outside FEED, sb_in1..3 and sb_r SHALL be driven to 0.
REQ-019 The block SHALL carry each issued index through a SBOX_LAT-deep valid/index delay line, and write sb_out1..3 into result-share bits 4i+3:4i when the delayed valid is high.
REQ-020 The last result SHALL be written at cycle 16+SBOX_LAT; done SHALL be 1 at cycle 17+SBOX_LAT (cycle 20 for SBOX_LAT=3).
REQ-021 busy SHALL be 1 from cycle 1 through cycle 16+SBOX_LAT and 0 in DONE and IDLE.
REQ-022 state*_out SHALL be the result registers; they are valid from the done cycle and held until the first write of the next layer.
REQ-023 Shares SHALL never be combined: no logic may mix bits of different share indices.
REQ-024 A start accepted in the DONE cycle SHALL begin a new FEED at the next cycle with no idle gap.

Reset
REQ-025 While rst_i=0, the FSM SHALL go to IDLE, and busy, done, sb_in*, sb_r, state*_out, the delay line and the captured shares SHALL all be 0, asynchronously.
REQ-026 Reset mid-layer SHALL abandon the layer with no done pulse; the first start after rst_i rises SHALL run normally.

Configuration
REQ-027 With macro NIBBLE_SHUFFLE_EN defined, i_k SHALL be (seed + k) mod 16, wrapping 15->0, and the per-nibble write index SHALL follow the delay line.
REQ-028 Without NIBBLE_SHUFFLE_EN, i_k SHALL be k, shuffle_seed SHALL be unused, and no seed register SHALL exist.
REQ-029 Latency, busy and done timing SHALL be identical with and without NIBBLE_SHUFFLE_EN.

Verification
REQ-030 Bench setup: the team's 3-share PRESENT S-box core, SBOX_LAT=3. Stimulus: state1_in=0x0123456789ABCDEF, state2_in=state3_in=0, start at cycle 0. Required: done at cycle 20 only, and XOR of out shares = 0xC56B90AD3EF84712.
REQ-031 Stimulus: random nonzero state2_in/state3_in with the same XOR as REQ-030. Required: same unshared result; all sb_in* = 0 outside cycles 1..16.
REQ-032 Stimulus: start pulses at cycles 5 and 12 during the layer. Required: ignored, single done at cycle 20, result unchanged.
REQ-033 Stimulus: start in the done cycle with new data. Required: busy=1 the next cycle, second done exactly 20 cycles after the first, correct second result.
REQ-034 Stimulus: rst_i low at cycle 8. Required: all outputs 0 immediately, no done pulse; a restart yields the correct result.
REQ-035 Stimulus: NIBBLE_SHUFFLE_EN defined, seed=0xE. Required: first issued index 14, then 15, 0, 1, ...; result identical to REQ-030.

Source files
------------

// File: rtl/sbox_layer_ctrl.sv
// sbox_layer_ctrl -- drives one masked S-box layer over a 64-bit, 3-share state.
//
// A start in IDLE or DONE captures the three input shares. The block then
// feeds 16 nibbles (one per cycle) to an external S-box core with SBOX_LAT
// cycles of latency. It waits for the core pipeline to drain, writes each
// result nibble back into per-share result registers, and pulses done.
//
// Optional feature (macro NIBBLE_SHUFFLE_EN): when defined, the first nibble
// index is taken from shuffle_seed at start, and the indices then wrap
// upward mod 16. When undefined, nibbles are issued in order 0..15 and
// shuffle_seed is ignored.
//
// Ports
//   clk, rst_i                      clock, async active-low reset
//   start                           run one layer (accepted in IDLE/DONE only)
//   state{1,2,3}_in   [63:0]        input shares
//   rnd_in            [7:0]         fresh randomness, forwarded on sb_r
//   shuffle_seed      [3:0]         first nibble index (shuffle build only)
//   sb_in{1,2,3}      [3:0]         nibble shares to S-box core
//   sb_r              [7:0]         randomness to S-box core
//   sb_out{1,2,3}     [3:0]         S-box core result shares
//   state{1,2,3}_out  [63:0]        substituted shares (result registers)
//   busy, done                      status / one-cycle completion pulse

// One share lane. It holds the captured share and the result share, and
// never sees the other shares.
module sbox_share_lane (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cap_en,
  input  logic        feed,
  input  logic [3:0]  rd_idx,
  input  logic        wr_en,
  input  logic [3:0]  wr_idx,
  input  logic [63:0] share_in,
  input  logic [3:0]  res_nib,
  output logic [3:0]  nib_out,
  output logic [63:0] share_out
);
  logic [63:0] cap_q;
  logic [63:0] res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= '0;
      res_q <= '0;
    end else begin
      if (cap_en) cap_q <= share_in;
      if (wr_en)  res_q[{wr_idx, 2'b00} +: 4] <= res_nib;
    end
  end

  assign nib_out   = feed ? cap_q[{rd_idx, 2'b00} +: 4] : 4'h0;
  assign share_out = res_q;
endmodule

module sbox_layer_ctrl #(
  parameter int SBOX_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        start,
  input  logic [63:0] state1_in,
  input  logic [63:0] state2_in,
  input  logic [63:0] state3_in,
  input  logic [7:0]  rnd_in,
  input  logic [3:0]  shuffle_seed,
  output logic [3:0]  sb_in1,
  output logic [3:0]  sb_in2,
  output logic [3:0]  sb_in3,
  output logic [7:0]  sb_r,
  input  logic [3:0]  sb_out1,
  input  logic [3:0]  sb_out2,
  input  logic [3:0]  sb_out3,
  output logic [63:0] state1_out,
  output logic [63:0] state2_out,
  output logic [63:0] state3_out,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t     st;
  logic [3:0] cnt;     // FEED: nibble count k; DRAIN: drain cycle count
  logic [3:0] rd_idx;
  logic       feed;
  logic       cap_en;

  // Issued-nibble delay line, aligned with the core latency.
  logic [SBOX_LAT:1]      vld_pipe;
  logic [SBOX_LAT:1][3:0] idx_pipe;

  assign feed   = (st == FEED);
  assign cap_en = start && (st == IDLE || st == DONE);

`ifdef NIBBLE_SHUFFLE_EN
  logic [3:0] seed_q;
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i)      seed_q <= '0;
    else if (cap_en) seed_q <= shuffle_seed;
  end
  assign rd_idx = seed_q + cnt;  // wraps 15 -> 0
`else
  // Seed input is deliberately unconsumed in the in-order build.
  logic unused_seed;
  assign unused_seed = ^shuffle_seed;
  assign rd_idx      = cnt;
`endif

  // Control FSM. busy/done are registered alongside the state.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      st   <= IDLE;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE, DONE: begin
          cnt <= '0;
          if (start) begin
            st   <= FEED;
            busy <= 1'b1;
          end else begin
            st   <= IDLE;
            busy <= 1'b0;
          end
        end
        FEED: begin
          if (cnt == 4'd15) begin
            st  <= DRAIN;
            cnt <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DRAIN: begin
          if (cnt == 4'(SBOX_LAT - 1)) begin
            st   <= DONE;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          st   <= IDLE;
          cnt  <= '0;
          busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[1] <= feed;
      idx_pipe[1] <= rd_idx;
      for (int j = 2; j <= SBOX_LAT; j++) begin
        vld_pipe[j] <= vld_pipe[j-1];
        idx_pipe[j] <= idx_pipe[j-1];
      end
    end
  end

  logic [2:0][63:0] sh_in, sh_out;
  logic [2:0][3:0]  nib, res;

  assign sh_in = {state3_in, state2_in, state1_in};
  assign res   = {sb_out3, sb_out2, sb_out1};

  for (genvar s = 0; s < 3; s++) begin : g_lane
    sbox_share_lane u_lane (
      .clk       (clk),
      .rst_n     (rst_i),
      .cap_en    (cap_en),
      .feed      (feed),
      .rd_idx    (rd_idx),
      .wr_en     (vld_pipe[SBOX_LAT]),
      .wr_idx    (idx_pipe[SBOX_LAT]),
      .share_in  (sh_in[s]),
      .res_nib   (res[s]),
      .nib_out   (nib[s]),
      .share_out (sh_out[s])
    );
  end

  assign sb_in1     = nib[0];
  assign sb_in2     = nib[1];
  assign sb_in3     = nib[2];
  assign sb_r       = feed ? rnd_in : 8'h00;
  assign state1_out = sh_out[0];
  assign state2_out = sh_out[1];
  assign state3_out = sh_out[2];
endmodule

// File: tb/tb_sbox_layer_ctrl.sv
// Bench for sbox_layer_ctrl. It includes a behavioural 3-share PRESENT S-box
// core with SBOX_LAT cycles of latency. Expected values come from the
// PRESENT table applied to the unshared state.
module tb_sbox_layer_ctrl;
  localparam int LAT = 3;
  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] PTS = 64'hC56B90AD3EF84712;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        start = 1'b0;
  logic [63:0] state1_in = '0, state2_in = '0, state3_in = '0;
  logic [7:0]  rnd_in = '0;
  logic [3:0]  shuffle_seed = '0;
  logic [3:0]  sb_in1, sb_in2, sb_in3, sb_out1, sb_out2, sb_out3;
  logic [7:0]  sb_r;
  logic [63:0] state1_out, state2_out, state3_out;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sbox_layer_ctrl #(.SBOX_LAT(LAT)) dut (
    .clk(clk), .rst_i(rst_i), .start(start),
    .state1_in(state1_in), .state2_in(state2_in), .state3_in(state3_in),
    .rnd_in(rnd_in), .shuffle_seed(shuffle_seed),
    .sb_in1(sb_in1), .sb_in2(sb_in2), .sb_in3(sb_in3), .sb_r(sb_r),
    .sb_out1(sb_out1), .sb_out2(sb_out2), .sb_out3(sb_out3),
    .state1_out(state1_out), .state2_out(state2_out), .state3_out(state3_out),
    .busy(busy), .done(done)
  );

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h21748FE3DA09B65C;  // S(0)=C in nibble 0 ... S(F)=2 in nibble 15
    return tbl[x*4 +: 4];
  endfunction

  function automatic logic [63:0] present_layer(input logic [63:0] p);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[i*4 +: 4] = sbox(p[i*4 +: 4]);
    return r;
  endfunction

  // Behavioural core: unmasks the nibble, substitutes it, and re-masks it
  // with the 8 random bits. The result appears LAT cycles after the input.
  logic [3:0] cx [1:LAT];
  logic [7:0] cr [1:LAT];
  always @(posedge clk) begin
    cx[1] <= sb_in1 ^ sb_in2 ^ sb_in3;
    cr[1] <= sb_r;
    for (int j = 2; j <= LAT; j++) begin
      cx[j] <= cx[j-1];
      cr[j] <= cr[j-1];
    end
  end
  assign sb_out2 = cr[LAT][3:0];
  assign sb_out3 = cr[LAT][7:4];
  assign sb_out1 = sbox(cx[LAT]) ^ cr[LAT][3:0] ^ cr[LAT][7:4];

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  function automatic int exp_idx(input logic [3:0] sd, input int k);
`ifdef NIBBLE_SHUFFLE_EN
    return (int'(sd) + k) % 16;
`else
    return k;
`endif
  endfunction

  // Runs one layer and checks it cycle by cycle. When pre=1, the start was
  // already given in the previous layer's done cycle. When chain=1, b* is
  // started in this layer's done cycle.
  task automatic run_layer(input string nm, input logic [63:0] a1, a2, a3,
                           input logic [3:0] sd, input bit pre,
                           input int sp1, sp2, input bit chain,
                           input logic [63:0] b1, b2, b3, input logic [3:0] bsd);
    logic [63:0] exp_res;
    int idx;
    exp_res = present_layer(a1 ^ a2 ^ a3);
    if (!pre) begin
      @(negedge clk);
      state1_in = a1; state2_in = a2; state3_in = a3;
      shuffle_seed = sd; start = 1'b1;
    end
    for (int n = 1; n <= 17 + LAT; n++) begin
      @(negedge clk);
      start = (n == sp1) || (n == sp2) || (chain && n == 17 + LAT);
      if (chain && n == 17 + LAT) begin
        state1_in = b1; state2_in = b2; state3_in = b3; shuffle_seed = bsd;
      end else begin
        state1_in = r64(); state2_in = r64(); state3_in = r64();
        shuffle_seed = 4'($urandom);
      end
      rnd_in = 8'($urandom);
      #1;
      checks++;
      if (busy !== (n <= 16 + LAT)) begin
        errors++;
        $display("FAIL %s busy cyc%0d: got %b want %b", nm, n, busy, (n <= 16 + LAT));
      end
      checks++;
      if (done !== (n == 17 + LAT)) begin
        errors++;
        $display("FAIL %s done cyc%0d: got %b want %b", nm, n, done, (n == 17 + LAT));
      end
      if (n <= 16) begin
        idx = exp_idx(sd, n - 1);
        checks++;
        if ({sb_in1, sb_in2, sb_in3, sb_r} !== {a1[idx*4 +: 4], a2[idx*4 +: 4], a3[idx*4 +: 4], rnd_in}) begin
          errors++;
          $display("FAIL %s feed cyc%0d idx%0d: got %h want %h", nm, n, idx,
                   {sb_in1, sb_in2, sb_in3, sb_r},
                   {a1[idx*4 +: 4], a2[idx*4 +: 4], a3[idx*4 +: 4], rnd_in});
        end
      end else begin
        checks++;
        if ({sb_in1, sb_in2, sb_in3, sb_r} !== 20'h0) begin
          errors++;
          $display("FAIL %s idle_sb cyc%0d: got %h want 0", nm, n, {sb_in1, sb_in2, sb_in3, sb_r});
        end
      end
      if (n == 17 + LAT) begin
        checks++;
        if ((state1_out ^ state2_out ^ state3_out) !== exp_res) begin
          errors++;
          $display("FAIL %s result: got %h want %h", nm, state1_out ^ state2_out ^ state3_out, exp_res);
        end
      end
    end
    if (!chain) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({busy, done, sb_in1, sb_in2, sb_in3, sb_r, state1_out, state2_out, state3_out} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b out1=%h want all 0", busy, done, state1_out);
    end
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic test_basic();
    run_layer("basic", PT, 64'h0, 64'h0, 4'hE, 0, -1, -1, 0, 0, 0, 0, 0);
    checks++;
    if ((state1_out ^ state2_out ^ state3_out) !== PTS) begin
      errors++;
      $display("FAIL basic_const: got %h want %h", state1_out ^ state2_out ^ state3_out, PTS);
    end
  endtask

  task automatic test_shared_random();
    logic [63:0] m2, m3, p;
    for (int t = 0; t < 4; t++) begin
      m2 = r64() | 64'h1;
      m3 = r64() | 64'h2;
      p  = (t < 2) ? PT : r64();
      run_layer("shared", p ^ m2 ^ m3, m2, m3, 4'($urandom), 0, -1, -1, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_spurious_start();
    run_layer("spurious", PT ^ 64'hA5A5, 64'h5A5A0000FFFF, 64'hFFFF00005A5A ^ 64'hA5A5 ^ 64'h5A5A0000FFFF,
              4'h3, 0, 5, 12, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [63:0] a2, a3, b1, b2, b3;
    a2 = r64(); a3 = r64();
    b1 = r64(); b2 = r64(); b3 = r64();
    run_layer("b2b_first", PT ^ a2 ^ a3, a2, a3, 4'h7, 0, -1, -1, 1, b1, b2, b3, 4'h9);
    run_layer("b2b_second", b1, b2, b3, 4'h9, 1, -1, -1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    state1_in = r64(); state2_in = r64(); state3_in = r64();
    shuffle_seed = 4'($urandom); start = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      start = 1'b0;
      rnd_in = 8'($urandom);
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if ({busy, done, sb_in1, sb_in2, sb_in3, sb_r, state1_out, state2_out, state3_out} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b sb=%h out1=%h want all 0",
               busy, done, {sb_in1, sb_in2, sb_in3, sb_r}, state1_out);
    end
    @(negedge clk); @(negedge clk);
    rst_i = 1'b1;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk); #1;
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("FAIL reset_mid_quiet cyc%0d: got busy=%b done=%b want 0 0", n, busy, done);
      end
    end
    run_layer("after_reset", PT, 64'h0, 64'h0, 4'h0, 0, -1, -1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shared_random();
    test_spurious_start();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
